// File: rtl/md_audio_pkg.sv
// Shared constants, the stereo sample type and the saturation helper for the
// Mega Drive style audio mixer.
package md_audio_pkg;

  localparam int PERIOD_DEF    = 144;
  localparam int PSG_SHIFT_DEF = 2;
  localparam int ACC_W         = 17;
  localparam int MIX_W         = 19;
  localparam int SAMPLE_W      = 16;
  localparam int CNT_W         = 8;

  localparam logic signed [MIX_W-1:0] SAT_MAX = 19'sd32767;
  localparam logic signed [MIX_W-1:0] SAT_MIN = -19'sd32768;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] l;
    logic signed [SAMPLE_W-1:0] r;
  } stereo_t;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [MIX_W-1:0] x);
    if (x > SAT_MAX)      return 16'sh7FFF;
    else if (x < SAT_MIN) return 16'sh8000;
    else                  return x[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/md_audio_fifo2.sv
// Two-entry FIFO for mixed stereo samples. A push into a full FIFO succeeds
// only when a pop happens on the same edge; the head reads as 0 when empty.
module md_audio_fifo2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        full_o,
  output logic        empty_o
);

  logic [31:0] mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  cnt_q;
  logic        do_push;
  logic        do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: the storage is reset along with the pointers because the outputs
  // must read as zero immediately on reset; larger memories would skip this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      // When full, the write slot is the head being popped this edge.
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/md_audio_mixer.sv
// Box-filters FM DAC words over one sample window, adds scaled PSG, saturates
// to 16 bits and queues the stereo result in a two-entry output FIFO.
module md_audio_mixer
  import md_audio_pkg::*;
#(
  parameter int PERIOD    = PERIOD_DEF,
  parameter int PSG_SHIFT = PSG_SHIFT_DEF
) (
  input  logic                       MCLK,
  input  logic                       SRES,
  input  logic        [8:0]          MOL,
  input  logic        [8:0]          MOR,
  input  logic        [15:0]         PSG,
  input  logic                       EN,
  input  logic                       MUTE,
  input  logic                       OUT_READY,
  input  logic                       OVF_CLR,
  output logic signed [SAMPLE_W-1:0] OUT_L,
  output logic signed [SAMPLE_W-1:0] OUT_R,
  output logic                       OUT_VALID,
  output logic                       OVF
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [ACC_W-1:0] sum_l, sum_r;
  logic signed [ACC_W-1:0] s1_l_q, s1_r_q;
  logic        [15:0]      s1_psg_q;
  logic                    s1_vld_q;
  logic        [16:0]      psg_scaled;
  logic signed [MIX_W-1:0] mix_l, mix_r;
  stereo_t                 s2_q;
  logic                    s2_vld_q;
  stereo_t                 push_data;
  stereo_t                 head;
  logic                    win_end;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    ovf_q, ovf_d;

  assign sum_l   = acc_l_q + ACC_W'($signed(MOL));
  assign sum_r   = acc_r_q + ACC_W'($signed(MOR));
  assign win_end = EN && (cnt_q == LAST);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d   = '0;
    acc_l_d = '0;
    acc_r_d = '0;
    if (EN && !win_end) begin
      cnt_d   = cnt_q + 1'b1;
      acc_l_d = sum_l;
      acc_r_d = sum_r;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      cnt_q    <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      s1_l_q   <= '0;
      s1_r_q   <= '0;
      s1_psg_q <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      s1_vld_q <= win_end;
      if (win_end) begin
        s1_l_q   <= sum_l;
        s1_r_q   <= sum_r;
        s1_psg_q <= PSG;
      end
    end
  end

  assign psg_scaled = {1'b0, s1_psg_q} >> PSG_SHIFT;
  assign mix_l      = MIX_W'(s1_l_q) + $signed({2'b00, psg_scaled});
  assign mix_r      = MIX_W'(s1_r_q) + $signed({2'b00, psg_scaled});

  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      s2_q     <= '0;
      s2_vld_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_q.l <= sat16(mix_l);
        s2_q.r <= sat16(mix_r);
      end
    end
  end

  assign push_data = MUTE ? '0 : s2_q;
  assign pop       = OUT_VALID && OUT_READY;

  md_audio_fifo2 u_fifo (
    .clk     (MCLK),
    .rst_n   (SRES),
    .push_i  (s2_vld_q),
    .pop_i   (pop),
    .data_i  (push_data),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A dropped sample sets the flag even when a clear is requested that edge.
  always_comb begin
    ovf_d = ovf_q;
    if (OVF_CLR) ovf_d = 1'b0;
    if (s2_vld_q && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign OUT_L     = head.l;
  assign OUT_R     = head.r;
  assign OUT_VALID = !fifo_empty;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_md_audio_mixer.sv
// Directed bench for md_audio_mixer: windowed sums, PSG mix and saturation,
// FIFO back-pressure/overflow, mute, EN abort and asynchronous reset.
module tb_md_audio_mixer;

  localparam int PERIOD    = 144;
  localparam int PSG_SHIFT = 2;

  logic               MCLK = 1'b0;
  logic               SRES;
  logic        [8:0]  MOL;
  logic        [8:0]  MOR;
  logic        [15:0] PSG;
  logic               EN;
  logic               MUTE;
  logic               OUT_READY;
  logic               OVF_CLR;
  logic signed [15:0] OUT_L;
  logic signed [15:0] OUT_R;
  logic               OUT_VALID;
  logic               OVF;

  int n_checks = 0;
  int n_fail   = 0;

  md_audio_mixer #(.PERIOD(PERIOD), .PSG_SHIFT(PSG_SHIFT)) dut (
    .MCLK      (MCLK),
    .SRES      (SRES),
    .MOL       (MOL),
    .MOR       (MOR),
    .PSG       (PSG),
    .EN        (EN),
    .MUTE      (MUTE),
    .OUT_READY (OUT_READY),
    .OVF_CLR   (OVF_CLR),
    .OUT_L     (OUT_L),
    .OUT_R     (OUT_R),
    .OUT_VALID (OUT_VALID),
    .OVF       (OVF)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    @(negedge MCLK);
  endtask

  // One full window, then the stage-2 edge, then the push edge with the
  // requested READY/OVF_CLR/MUTE levels applied on that push edge only.
  task automatic run_window(input logic [8:0] mol, input logic [8:0] mor,
                            input logic [15:0] psg, input logic ready,
                            input logic clr, input logic mute);
    MOL = mol; MOR = mor; PSG = psg; EN = 1'b1;
    repeat (PERIOD) tick();
    EN = 1'b0;
    tick();
    OUT_READY = ready; OVF_CLR = clr; MUTE = mute;
    tick();
    OUT_READY = 1'b0; OVF_CLR = 1'b0; MUTE = 1'b0;
  endtask

  task automatic pop_one();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  initial begin
    SRES = 1'b1; MOL = '0; MOR = '0; PSG = '0; EN = 1'b0;
    MUTE = 1'b0; OUT_READY = 1'b0; OVF_CLR = 1'b0;
    #3 SRES = 1'b0;
    repeat (3) @(negedge MCLK);
    check("rst_out_l", OUT_L, 0);
    check("rst_out_r", OUT_R, 0);
    check("rst_valid", OUT_VALID, 0);
    check("rst_ovf", OVF, 0);
    SRES = 1'b1;
    tick();

    // +1 / -1 for one window: valid exactly two edges after the last sample
    MOL = 9'h001; MOR = 9'h1FF; PSG = 16'h0000; EN = 1'b1;
    repeat (PERIOD) tick();
    EN = 1'b0;
    check("lat_valid_e0", OUT_VALID, 0);
    tick();
    check("lat_valid_e1", OUT_VALID, 0);
    tick();
    check("lat_valid_e2", OUT_VALID, 1);
    check("basic_l", OUT_L, 144);
    check("basic_r", OUT_R, -144);
    pop_one();
    check("pop_empty_valid", OUT_VALID, 0);
    check("pop_empty_l", OUT_L, 0);

    // non-saturating PSG mix: 288+1024, -432+1024
    run_window(9'h002, 9'h1FD, 16'h1000, 1'b0, 1'b0, 1'b0);
    check("psg_mix_l", OUT_L, 1312);
    check("psg_mix_r", OUT_R, 592);
    pop_one();

    // 36720+16383 saturates high; -36864+16383 stays in range
    run_window(9'h0FF, 9'h100, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    check("sat_hi_l", OUT_L, 32767);
    check("psg_neg_r", OUT_R, -20481);
    pop_one();
    run_window(9'h0FF, 9'h100, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("sat_hi_nopsg_l", OUT_L, 32767);
    check("sat_lo_r", OUT_R, -32768);
    pop_one();

    // back-pressure: 1440, 2880 stored; third push dropped with clear on same edge
    run_window(9'd10, 9'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_window(9'd20, 9'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("full_ovf_clear", OVF, 0);
    check("full_head", OUT_L, 1440);
    run_window(9'd30, 9'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("ovf_set_wins", OVF, 1);
    check("ovf_head_kept", OUT_L, 1440);
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    check("ovf_cleared", OVF, 0);

    // full FIFO, pop and push on the same edge
    run_window(9'd30, 9'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("pp_ovf", OVF, 0);
    check("pp_head", OUT_L, 2880);
    pop_one();
    check("pp_second", OUT_L, 4320);
    pop_one();
    check("pp_drained", OUT_VALID, 0);

    // READY with an empty FIFO does nothing
    OUT_READY = 1'b1;
    repeat (3) tick();
    OUT_READY = 1'b0;
    check("ready_no_valid", OUT_VALID, 0);
    check("ready_no_valid_l", OUT_L, 0);

    // mute at push time
    run_window(9'h001, 9'h001, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("mute_valid", OUT_VALID, 1);
    check("mute_l", OUT_L, 0);
    check("mute_r", OUT_R, 0);
    pop_one();

    // EN dropped mid-window discards the partial sum
    MOL = 9'd100; MOR = 9'd100; EN = 1'b1;
    repeat (50) tick();
    EN = 1'b0;
    repeat (4) tick();
    check("abort_no_push", OUT_VALID, 0);
    run_window(9'h001, 9'h1FF, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("abort_fresh_l", OUT_L, 144);
    check("abort_fresh_r", OUT_R, -144);
    pop_one();

    // fill and overflow, then reset mid-window at count 70
    run_window(9'd5, 9'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_window(9'd5, 9'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_window(9'd5, 9'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("pre_rst_ovf", OVF, 1);
    check("pre_rst_l", OUT_L, 720);
    MOL = 9'd7; MOR = 9'd7; EN = 1'b1;
    repeat (70) tick();
    #2 SRES = 1'b0;
    #1;
    check("arst_valid", OUT_VALID, 0);
    check("arst_l", OUT_L, 0);
    check("arst_r", OUT_R, 0);
    check("arst_ovf", OVF, 0);
    EN = 1'b0;
    @(negedge MCLK);
    SRES = 1'b1;
    run_window(9'd3, 9'h1FD, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("post_rst_l", OUT_L, 432);
    check("post_rst_r", OUT_R, -432);
    check("post_rst_ovf", OVF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_audio_mixer.md
MD_AUDIO_MIXER -- requirements
Module: md_audio_mixer

Interface
REQ-001 Parameter PERIOD, default 144: MCLK cycles per output sample window (equals the FM sample period); legal range 2..256.
REQ-002 Parameter PSG_SHIFT, default 2: right shift applied to PSG before mixing; legal range 0..8.
REQ-003 MCLK  in  1  sole clock; all state changes on rising edge.
REQ-004 SRES  in  1  reset, asynchronous assert, active-low.
REQ-005 MOL  in  9  FM left DAC word, two's complement signed.
REQ-006 MOR  in  9  FM right DAC word, two's complement signed.
REQ-007 PSG  in  16  PSG level, unsigned, mixed equally into both channels.
REQ-008 EN  in  1  high: windows run; low: counter and accumulators held at 0, no pushes.
REQ-009 MUTE  in  1  high at push time: pushed sample is 0/0.
REQ-010 OUT_READY  in  1  downstream accepts the head sample when high with OUT_VALID.
REQ-011 OVF_CLR  in  1  synchronous clear of OVF.
REQ-012 OUT_L, OUT_R  out  16 each  head sample, signed; 0 when FIFO empty.
REQ-013 OUT_VALID  out  1  FIFO non-empty.
REQ-014 OVF  out  1  sticky overflow flag.

Function
REQ-015 The window counter SHALL count 0..PERIOD-1 while EN=1 and wrap to 0 after PERIOD-1.
REQ-016 Each EN=1 cycle SHALL add the sign-extended MOL/MOR to 17-bit signed accumulators ACC_L/ACC_R.
REQ-017 At count PERIOD-1, ACC+current sample SHALL be latched into stage-1 registers with PSG sampled that cycle, and ACC SHALL clear to 0 in the same edge.
REQ-018 Stage 2 SHALL compute mix = stage1_sum + ({1'b0,PSG} >> PSG_SHIFT) in 19-bit signed and saturate to [-32768, 32767].
REQ-019 The saturated pair (or 0/0 if MUTE) SHALL be pushed into a 2-entry FIFO; OUT_VALID rises 2 MCLK after the last window sample.
REQ-020 Pop SHALL occur on an edge where OUT_VALID=1 and OUT_READY=1; OUT_L/OUT_R then present the next entry or 0.
REQ-021 Push into a full FIFO without simultaneous pop SHALL drop the new sample and set OVF; stored entries unchanged.
REQ-022 Push and pop on the same edge when full SHALL both succeed; OVF unchanged.
REQ-023 OVF_CLR and an overflow on the same edge: OVF SHALL end at 1 (set wins).
REQ-024 EN falling mid-window SHALL discard the partial window (counter, ACC to 0); pipeline stages and FIFO continue to drain.
REQ-025 OUT_READY without OUT_VALID SHALL have no effect.

Reset
REQ-026 SRES=0 SHALL asynchronously clear counter, ACC, stage registers, FIFO pointers/entries, OUT_L, OUT_R, OUT_VALID, OVF to 0.
REQ-027 After SRES release, the first window SHALL start at count 0 on the first EN=1 edge and contain exactly PERIOD samples.

Structure
REQ-028 Shared package md_audio_pkg SHALL hold PERIOD/PSG_SHIFT defaults, accumulator width (17), mix width (19), saturation limits.
REQ-029 The FIFO SHALL be sub-module md_audio_fifo2 (2 entries × 32 bits, push/pop/full/empty); all else in md_audio_mixer.

Verification
REQ-030 MOL=+1, MOR=-1, PSG=0, 144 cycles -> OUT_L=144, OUT_R=-144, OUT_VALID 2 cycles after window end.
REQ-031 MOL=+255, PSG=0xFFFF, PSG_SHIFT=2 -> 36720+16383 saturates, OUT_L=32767; MOR=-256, PSG=0 -> OUT_R=-32768.
REQ-032 OUT_READY=0 for 3 windows (values 10,20,30 per-sample MOL) -> FIFO holds 1440,2880; OVF=1 after 3rd push; OVF_CLR -> 0.
REQ-033 FIFO full, OUT_READY=1 on push edge -> pop 1440, push 4320, OVF stays 0.
REQ-034 SRES=0 at count 70 -> all outputs 0 immediately; after release, first sample sums exactly 144 new inputs.
REQ-035 MUTE=1 at push with MOL=+1 -> OUT_L=0, OUT_R=0, OUT_VALID=1.
